i2c_write_arbiter: RTL and testbench

- Shares one I2C word-write engine between two requesters: port 0 is the power-monitor init sequencer, port 1 is runtime host writes.
- Arbitrates between the two requesters and drives the engine's GO/END_OK handshake.
- Captures the final acknowledge and retries NACKed writes up to a limit.
- Guards every transfer with a timeout and reports per-request completion status.

---
 rtl/i2c_write_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// Shares one I2C word-write engine between two requesters: round-robin grant,
// GO/END_OK handshake, NACK retry and a per-attempt timeout with per-port status.
module i2c_write_arbiter #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h80,
  parameter int unsigned GO_CYCLES  = 4,
  parameter int unsigned TIMEOUT    = 20000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        REQ0_VALID,
  input  logic [7:0]  REQ0_POINTER,
  input  logic [15:0] REQ0_DATA,
  output logic        REQ0_READY,
  output logic        REQ0_DONE,
  output logic        REQ0_ERR,
  input  logic        REQ1_VALID,
  input  logic [7:0]  REQ1_POINTER,
  input  logic [15:0] REQ1_DATA,
  output logic        REQ1_READY,
  output logic        REQ1_DONE,
  output logic        REQ1_ERR,
  output logic        WR_GO,
  output logic [7:0]  WR_SLAVE_ADDRESS,
  output logic [7:0]  WR_POINTER,
  output logic [15:0] WR_WDATA16,
  input  logic        WR_END_OK,
  input  logic        WR_ACK_OK,
  output logic        BUSY,
  output logic        OWNER
);

  localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam int unsigned GO_W  = ($clog2(GO_CYCLES + 1) > 1) ? $clog2(GO_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX     = {TMO_W{1'b1}};
  localparam logic [GO_W-1:0]  GO_LAST     = GO_W'(GO_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GO_HI      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_XFER       = 3'd3,
    ST_CHECK      = 3'd4,
    ST_RETRY_GAP  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              grant_s;
  logic              grant_port_s;
  logic              tmo_hit_s;
  logic              go_last_s;
  logic              fin_s;
  logic              fin_err_s;
  logic              ready0_s;
  logic              ready1_s;
  logic              wr_go_s;
  logic              busy_s;

  logic [GO_W-1:0]   go_cnt_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [3:0]        retry_cnt_r;
  logic              ack_q_r;
  logic              last_r;
  logic              owner_r;
  logic [7:0]        pointer_r;
  logic [15:0]       wdata_r;
  logic              ready0_r;
  logic              ready1_r;
  logic              done0_r;
  logic              done1_r;
  logic              err0_r;
  logic              err1_r;
  logic              wr_go_r;
  logic              busy_r;

  assign tmo_hit_s = (tmo_cnt_r >= TMO_LAST);
  assign go_last_s = (go_cnt_r >= GO_LAST);

  // State register.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic, including the round-robin grant decision.
  always_comb begin
    state_s      = state_r;
    grant_s      = 1'b0;
    grant_port_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (WR_END_OK && REQ0_VALID && REQ1_VALID) begin
          grant_s      = 1'b1;
          grant_port_s = ~last_r;
        end else if (WR_END_OK && (REQ0_VALID || REQ1_VALID)) begin
          grant_s      = 1'b1;
          grant_port_s = REQ1_VALID;
        end else begin
          grant_s      = 1'b0;
          grant_port_s = 1'b0;
        end
        if (grant_s) begin
          state_s = ST_GO_HI;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GO_HI: begin
        if (go_last_s) begin
          state_s = ST_WAIT_START;
        end else begin
          state_s = ST_GO_HI;
        end
      end
      ST_WAIT_START: begin
        if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else if (!WR_END_OK) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_WAIT_START;
        end
      end
      ST_XFER: begin
        if (tmo_hit_s) begin
          state_s = ST_IDLE;
        end else if (WR_END_OK) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_CHECK: begin
        if (ack_q_r) begin
          state_s = ST_IDLE;
        end else if (retry_cnt_r < RETRY_LIMIT) begin
          state_s = ST_RETRY_GAP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RETRY_GAP: begin
        state_s = ST_GO_HI;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered handshake and status outputs.
  always_comb begin
    fin_s     = 1'b0;
    fin_err_s = 1'b0;
    case (state_r)
      ST_WAIT_START, ST_XFER: begin
        fin_s     = tmo_hit_s;
        fin_err_s = 1'b1;
      end
      ST_CHECK: begin
        if (ack_q_r) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b0;
        end else if (retry_cnt_r >= RETRY_LIMIT) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
        end else begin
          fin_s     = 1'b0;
          fin_err_s = 1'b0;
        end
      end
      default: begin
        fin_s     = 1'b0;
        fin_err_s = 1'b0;
      end
    endcase
    ready0_s = grant_s & ~grant_port_s;
    ready1_s = grant_s & grant_port_s;
    wr_go_s  = (state_s == ST_GO_HI);
    // BUSY stays up through the DONE cycle and falls one cycle later.
    busy_s   = (state_s != ST_IDLE) | fin_s;
  end

  // Registered outputs.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      ready0_r <= 1'b0;
      ready1_r <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      wr_go_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ready0_r <= ready0_s;
      ready1_r <= ready1_s;
      done0_r  <= fin_s & ~owner_r;
      done1_r  <= fin_s & owner_r;
      err0_r   <= fin_s & fin_err_s & ~owner_r;
      err1_r   <= fin_s & fin_err_s & owner_r;
      wr_go_r  <= wr_go_s;
      busy_r   <= busy_s;
    end
  end

  // Request capture, ownership and the GO / timeout / retry / ack bookkeeping.
  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      pointer_r   <= 8'h00;
      wdata_r     <= 16'h0000;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      retry_cnt_r <= 4'd0;
      go_cnt_r    <= {GO_W{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      ack_q_r     <= 1'b0;
    end else begin
      if (grant_s) begin
        pointer_r   <= grant_port_s ? REQ1_POINTER : REQ0_POINTER;
        wdata_r     <= grant_port_s ? REQ1_DATA : REQ0_DATA;
        owner_r     <= grant_port_s;
        last_r      <= grant_port_s;
        retry_cnt_r <= 4'd0;
      end else if (state_r == ST_CHECK && !ack_q_r && retry_cnt_r < RETRY_LIMIT) begin
        retry_cnt_r <= retry_cnt_r + 4'd1;
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end

      if (state_r == ST_GO_HI) begin
        go_cnt_r <= go_cnt_r + {{(GO_W-1){1'b0}}, 1'b1};
      end else begin
        go_cnt_r <= {GO_W{1'b0}};
      end

      // Timeout counts from the first GO_HI cycle of each attempt.
      if (state_r == ST_IDLE || state_r == ST_CHECK || state_r == ST_RETRY_GAP) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (tmo_cnt_r != TMO_MAX) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end

      // The engine clears ACK_OK on the edge it raises END_OK, so only sample while busy.
      if (state_r == ST_GO_HI) begin
        ack_q_r <= 1'b0;
      end else if (state_r == ST_XFER && !WR_END_OK) begin
        ack_q_r <= WR_ACK_OK;
      end else begin
        ack_q_r <= ack_q_r;
      end
    end
  end

  assign REQ0_READY       = ready0_r;
  assign REQ1_READY       = ready1_r;
  assign REQ0_DONE        = done0_r;
  assign REQ1_DONE        = done1_r;
  assign REQ0_ERR         = err0_r;
  assign REQ1_ERR         = err1_r;
  assign WR_GO            = wr_go_r;
  assign WR_SLAVE_ADDRESS = SLAVE_ADDR;
  assign WR_POINTER       = pointer_r;
  assign WR_WDATA16       = wdata_r;
  assign BUSY             = busy_r;
  assign OWNER            = owner_r;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter with a behavioural word-write engine model.
module tb_i2c_write_arbiter;

  localparam int TMO    = 20000;
  localparam int GO_LEN = 4;
  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_NACK1 = 2;
  localparam int M_HANG  = 3;

  logic        PT_CK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ0_VALID = 1'b0;
  logic [7:0]  REQ0_POINTER = 8'h00;
  logic [15:0] REQ0_DATA = 16'h0000;
  logic        REQ0_READY, REQ0_DONE, REQ0_ERR;
  logic        REQ1_VALID = 1'b0;
  logic [7:0]  REQ1_POINTER = 8'h00;
  logic [15:0] REQ1_DATA = 16'h0000;
  logic        REQ1_READY, REQ1_DONE, REQ1_ERR;
  logic        WR_GO;
  logic [7:0]  WR_SLAVE_ADDRESS, WR_POINTER;
  logic [15:0] WR_WDATA16;
  logic        WR_END_OK;
  logic        WR_ACK_OK = 1'b0;
  logic        BUSY, OWNER;

  i2c_write_arbiter dut (
    .PT_CK(PT_CK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_POINTER(REQ0_POINTER), .REQ0_DATA(REQ0_DATA),
    .REQ0_READY(REQ0_READY), .REQ0_DONE(REQ0_DONE), .REQ0_ERR(REQ0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_POINTER(REQ1_POINTER), .REQ1_DATA(REQ1_DATA),
    .REQ1_READY(REQ1_READY), .REQ1_DONE(REQ1_DONE), .REQ1_ERR(REQ1_ERR),
    .WR_GO(WR_GO), .WR_SLAVE_ADDRESS(WR_SLAVE_ADDRESS), .WR_POINTER(WR_POINTER),
    .WR_WDATA16(WR_WDATA16), .WR_END_OK(WR_END_OK), .WR_ACK_OK(WR_ACK_OK),
    .BUSY(BUSY), .OWNER(OWNER)
  );

  always #5 PT_CK = ~PT_CK;

  int cyc = 0;
  always @(posedge PT_CK) cyc++;

  // Engine model: starts on a GO burst, busy 9 cycles, raises END_OK and clears ACK_OK together.
  int   go_bursts = 0, base_bursts = 0, go_len = 0, go_len_last = 0, e_cnt = 0, eng_mode = 0;
  bit   e_busy = 1'b0, go_prev = 1'b0, eng_hold = 1'b0;
  logic e_end_ok = 1'b1;
  assign WR_END_OK = e_end_ok & ~eng_hold;

  always @(negedge PT_CK) begin
    if (RESET) begin
      e_busy = 1'b0; e_end_ok = 1'b1; WR_ACK_OK = 1'b0; go_prev = 1'b0; go_len = 0;
    end else begin
      if (WR_GO && !go_prev) begin
        go_bursts++; go_len = 1;
      end else if (WR_GO) begin
        go_len++;
      end else if (go_prev) begin
        go_len_last = go_len;
      end
      go_prev = WR_GO;
      if (!e_busy) begin
        if (WR_GO && go_len == 1) begin
          e_busy = 1'b1; e_cnt = 8; e_end_ok = 1'b0;
          WR_ACK_OK = (eng_mode == M_ACK) || (eng_mode == M_NACK1 && (go_bursts - base_bursts) >= 2);
        end
      end else if (eng_mode != M_HANG) begin
        if (e_cnt == 0) begin
          e_busy = 1'b0; e_end_ok = 1'b1; WR_ACK_OK = 1'b0;
        end else begin
          e_cnt--;
        end
      end
    end
  end

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  typedef struct {
    logic        v0, v1;
    logic [7:0]  p0;
    logic [15:0] d0;
    logic [7:0]  p1;
    logic [15:0] d1;
    int          mode;
    logic        exp_port;
    logic        exp_err;
    int          exp_bursts;
  } vec_t;

  // Waits for DONE on the owning port, then checks status, burst count and BUSY release.
  task automatic finish_xfer(input logic port, input logic exp_err, input int exp_bursts);
    bit seen = 1'b0, wrong = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge PT_CK);
      if (port ? REQ0_DONE : REQ1_DONE) wrong = 1'b1;
      if (port ? REQ1_DONE : REQ0_DONE) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("done_err", {31'd0, (port ? REQ1_ERR : REQ0_ERR)}, {31'd0, exp_err});
    chk("done_other_port", {31'd0, wrong}, 32'd0);
    chk("busy_in_done", {31'd0, BUSY}, 32'd1);
    chk("go_bursts", go_bursts - base_bursts, exp_bursts);
    chk("go_length", go_len_last, GO_LEN);
    @(negedge PT_CK);
    chk("busy_after_done", {31'd0, BUSY}, 32'd0);
  endtask

  task automatic run_row(input vec_t v);
    @(negedge PT_CK);
    eng_mode = v.mode; base_bursts = go_bursts;
    REQ0_POINTER = v.p0; REQ0_DATA = v.d0; REQ0_VALID = v.v0;
    REQ1_POINTER = v.p1; REQ1_DATA = v.d1; REQ1_VALID = v.v1;
    @(negedge PT_CK);
    chk("ready0", {31'd0, REQ0_READY}, {31'd0, ~v.exp_port});
    chk("ready1", {31'd0, REQ1_READY}, {31'd0, v.exp_port});
    chk("owner", {31'd0, OWNER}, {31'd0, v.exp_port});
    chk("wr_pointer", {24'd0, WR_POINTER}, {24'd0, (v.exp_port ? v.p1 : v.p0)});
    chk("wr_wdata", {16'd0, WR_WDATA16}, {16'd0, (v.exp_port ? v.d1 : v.d0)});
    chk("go_after_grant", {31'd0, WR_GO}, 32'd1);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    finish_xfer(v.exp_port, v.exp_err, v.exp_bursts);
  endtask

  task automatic reset_mid(input int k, input logic exp_go_before);
    vec_t tie;
    @(negedge PT_CK);
    eng_mode = M_ACK; base_bursts = go_bursts;
    REQ0_POINTER = 8'h21; REQ0_DATA = 16'hBEEF; REQ0_VALID = 1'b1;
    @(negedge PT_CK);
    chk("rst_ready0", {31'd0, REQ0_READY}, 32'd1);
    REQ0_VALID = 1'b0;
    repeat (k) @(negedge PT_CK);
    chk("rst_go_before", {31'd0, WR_GO}, {31'd0, exp_go_before});
    chk("rst_busy_before", {31'd0, BUSY}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_go_async", {31'd0, WR_GO}, 32'd0);
    chk("rst_busy_async", {31'd0, BUSY}, 32'd0);
    chk("rst_pulses_async", {28'd0, REQ0_READY, REQ0_DONE, REQ1_READY, REQ1_DONE}, 32'd0);
    chk("rst_owner_async", {31'd0, OWNER}, 32'd0);
    @(negedge PT_CK); @(negedge PT_CK);
    RESET = 1'b0;
    tie = '{1'b1, 1'b1, 8'h31, 16'h3131, 8'h32, 16'h3232, M_ACK, 1'b0, 1'b0, 1};
    run_row(tie);
  endtask

  vec_t vecs[7];
  int   t_go, t_done;
  bit   seen;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'h05, 16'h1234, 8'h0A, 16'hABCD, M_ACK,   1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 8'h05, 16'h1234, 8'h0A, 16'hABCD, M_ACK,   1'b1, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b1, 8'h06, 16'h2222, 8'h0B, 16'h3333, M_ACK,   1'b0, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 16'h0000, 8'h33, 16'h5555, M_NACK1, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b0, 8'h44, 16'h6666, 8'h00, 16'h0000, M_NACK,  1'b0, 1'b1, 3};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 16'h0000, 8'h55, 16'h7777, M_ACK,   1'b1, 1'b0, 1};
    vecs[6] = '{1'b1, 1'b1, 8'h66, 16'h8888, 8'h67, 16'h9999, M_ACK,   1'b0, 1'b0, 1};

    repeat (3) @(negedge PT_CK);
    chk("reset_go", {31'd0, WR_GO}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_owner", {31'd0, OWNER}, 32'd0);
    chk("reset_pulses", {26'd0, REQ0_READY, REQ0_DONE, REQ0_ERR, REQ1_READY, REQ1_DONE, REQ1_ERR}, 32'd0);
    chk("reset_slave_addr", {24'd0, WR_SLAVE_ADDRESS}, 32'h80);
    chk("reset_pointer", {8'd0, WR_POINTER, WR_WDATA16}, 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // Timeout: engine leaves idle and never returns.
    @(negedge PT_CK);
    eng_mode = M_HANG; base_bursts = go_bursts;
    REQ0_POINTER = 8'h77; REQ0_DATA = 16'h0F0F; REQ0_VALID = 1'b1;
    @(negedge PT_CK);
    chk("tmo_ready0", {31'd0, REQ0_READY}, 32'd1);
    chk("tmo_go_start", {31'd0, WR_GO}, 32'd1);
    t_go = cyc; t_done = 0; seen = 1'b0;
    REQ0_VALID = 1'b0;
    for (int i = 0; i < TMO + 200 && !seen; i++) begin
      @(negedge PT_CK);
      if (REQ0_DONE) begin seen = 1'b1; t_done = cyc; end
    end
    chk("tmo_done_seen", {31'd0, seen}, 32'd1);
    chk("tmo_latency", t_done - t_go, TMO);
    chk("tmo_err0", {31'd0, REQ0_ERR}, 32'd1);
    chk("tmo_go_low", {31'd0, WR_GO}, 32'd0);
    chk("tmo_bursts", go_bursts - base_bursts, 1);
    eng_mode = M_ACK;
    @(negedge PT_CK);
    chk("tmo_idle", {31'd0, BUSY}, 32'd0);
    base_bursts = go_bursts;
    REQ1_POINTER = 8'h78; REQ1_DATA = 16'hF0F0; REQ1_VALID = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PT_CK);
      if (REQ1_READY) seen = 1'b1;
    end
    chk("tmo_next_ready1", {31'd0, seen}, 32'd1);
    chk("tmo_next_pointer", {24'd0, WR_POINTER}, 32'h78);
    REQ1_VALID = 1'b0;
    finish_xfer(1'b1, 1'b0, 1);

    // Reset during GO_HI and during XFER.
    reset_mid(1, 1'b1);
    reset_mid(6, 1'b0);

    // Engine busy when the request arrives: no grant until END_OK returns.
    @(negedge PT_CK);
    eng_hold = 1'b1; eng_mode = M_ACK; base_bursts = go_bursts;
    REQ1_POINTER = 8'h90; REQ1_DATA = 16'h4321; REQ1_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PT_CK);
      chk("hold_no_ready1", {31'd0, REQ1_READY}, 32'd0);
    end
    eng_hold = 1'b0;
    @(negedge PT_CK);
    chk("hold_ready1", {31'd0, REQ1_READY}, 32'd1);
    chk("hold_data", {16'd0, WR_WDATA16}, 32'h4321);
    REQ1_VALID = 1'b0;
    finish_xfer(1'b1, 1'b0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
